// File: rtl/wb_stage_pkg.sv
// Shared constants, bus layout and FSM encoding for the writeback stage.
package wb_stage_pkg;

  localparam int MEM2WB_WD = 166;
  localparam int WB2ID_WD  = 70;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [4:0]  A0_ADDR     = 5'd10;

  typedef enum logic {
    WB_RUN  = 1'b0,
    WB_HALT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [31:0] inst;
  } mem2wb_t;

endpackage

// File: rtl/wb_perf_ctr.sv
// Cycle and retired-instruction counters for the writeback stage; both wrap modulo 2^64.
module wb_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        fire,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (run) begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (fire) instret_cnt <= instret_cnt + 64'd1;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM result, commits each instruction once, halts on ebreak.
// Define WB_PERF_EN to build in the cycle/instret counters.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [5:0]           stall,
  input  logic [MEM2WB_WD-1:0] mem2wb_bus,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [63:0]          rf_wdata,
  output logic [WB2ID_WD-1:0]  wb2id_fwd,
  output logic                 commit_valid,
  output logic [63:0]          commit_pc,
  output logic [31:0]          commit_inst,
  output logic                 halt,
  output logic [63:0]          halt_code,
  output logic [63:0]          cycle_cnt,
  output logic [63:0]          instret_cnt
);

  mem2wb_t   wb_r;
  logic      done_r;
  wb_state_e state, state_nxt;
  logic [63:0] a0_r;
  logic      clear, load, valid, fire;
  logic      unused_stall;

  assign unused_stall = ^stall[3:0];

  // A bubble is inserted when WB stalls but the stage downstream does not.
  assign clear = flush | (stall[4] & ~stall[5]);
  assign load  = ~stall[4];

  always_ff @(posedge clk) begin
    if (!rst_n)     wb_r <= '0;
    else if (clear) wb_r <= '0;
    else if (load)  wb_r <= mem2wb_t'(mem2wb_bus);
  end

  // done_r blocks a second commit while the same instruction is held by a stall.
  always_ff @(posedge clk) begin
    if (!rst_n)             done_r <= 1'b0;
    else if (clear || load) done_r <= 1'b0;
    else if (fire)          done_r <= 1'b1;
  end

  assign valid = (wb_r.inst != 32'h0);
  assign fire  = valid & ~done_r & (state == WB_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WB_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    halt      = 1'b0;
    case (state)
      WB_RUN:  if (fire && (wb_r.inst == EBREAK_INST)) state_nxt = WB_HALT;
      WB_HALT: halt = 1'b1;
      default: state_nxt = WB_RUN;
    endcase
  end

  assign rf_we        = fire & wb_r.we & (wb_r.waddr != 5'd0);
  assign rf_waddr     = wb_r.waddr;
  assign rf_wdata     = wb_r.wdata;
  assign wb2id_fwd    = {rf_we, rf_waddr, rf_wdata};
  assign commit_valid = fire;
  assign commit_pc    = wb_r.pc;
  assign commit_inst  = wb_r.inst;

  // ebreak never writes, so the value captured here is final once halted.
  always_ff @(posedge clk) begin
    if (!rst_n)                            a0_r <= '0;
    else if (rf_we && rf_waddr == A0_ADDR) a0_r <= rf_wdata;
  end

  assign halt_code = a0_r;

`ifdef WB_PERF_EN
  logic run;
  assign run = (state == WB_RUN);

  wb_perf_ctr u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .fire        (fire),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = 64'h0;
  assign instret_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_stage;

`ifdef WB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [5:0]   stall;
  logic [165:0] mem2wb_bus;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [63:0]  rf_wdata;
  logic [69:0]  wb2id_fwd;
  logic         commit_valid;
  logic [63:0]  commit_pc;
  logic [31:0]  commit_inst;
  logic         halt;
  logic [63:0]  halt_code;
  logic [63:0]  cycle_cnt;
  logic [63:0]  instret_cnt;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall), .mem2wb_bus(mem2wb_bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb2id_fwd(wb2id_fwd),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .halt(halt), .halt_code(halt_code), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction sitting in WB, whether it has already retired,
  // whether the core has halted, the last value written to a0, and the two counters.
  logic [165:0] m_bus = '0;
  bit           m_retired = 0;
  bit           m_halted = 0;
  logic [63:0]  m_a0 = '0, m_cyc = '0, m_ret = '0;

  function automatic logic [165:0] mk_bus(input logic we, input logic [4:0] wa,
                                          input logic [63:0] wd, input logic [63:0] pc,
                                          input logic [31:0] inst);
    return {we, wa, wd, pc, inst};
  endfunction

  function automatic bit m_fire();
    return (m_bus[31:0] != 32'h0) && !m_retired && !m_halted;
  endfunction

  function automatic bit m_we();
    return m_fire() && m_bus[165] && (m_bus[164:160] != 5'd0);
  endfunction

  function automatic logic [63:0] e_cyc();
    return PERF ? m_cyc : 64'h0;
  endfunction

  function automatic logic [63:0] e_ret();
    return PERF ? m_ret : 64'h0;
  endfunction

  task automatic model_step(input logic r, input logic f, input logic [5:0] s, input logic [165:0] b);
    bit fi, w;
    fi = m_fire();
    w  = m_we();
    if (!r) begin
      m_bus = '0; m_retired = 0; m_halted = 0; m_a0 = '0; m_cyc = '0; m_ret = '0;
    end else begin
      if (w && m_bus[164:160] == 5'd10) m_a0 = m_bus[159:96];
      if (!m_halted) begin
        m_cyc = m_cyc + 64'd1;
        if (fi) m_ret = m_ret + 64'd1;
      end
      if (fi && m_bus[31:0] == EBREAK) m_halted = 1;
      if (f || (s[4] && !s[5])) begin m_bus = '0; m_retired = 0; end
      else if (!s[4])           begin m_bus = b;  m_retired = 0; end
      else if (fi)              m_retired = 1;
    end
  endtask

  // Drive inputs after a falling edge, advance the model, then return at the next falling edge.
  task automatic drive(input logic r, input logic f, input logic [5:0] s, input logic [165:0] b);
    rst_n = r; flush = f; stall = s; mem2wb_bus = b;
    model_step(r, f, s, b);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 6'h3f, mk_bus(1'b1, 5'd10, 64'h1234, 64'h8000_0000, 32'h0050_0293));
    drive(1'b0, 1'b0, 6'h00, mk_bus(1'b1, 5'd10, 64'h1234, 64'h8000_0000, EBREAK));
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b want 0", commit_valid); end
    checks++; if (commit_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", commit_inst); end
    checks++; if (wb2id_fwd !== 70'h0) begin errors++; $display("FAIL reset_fwd: got %h want 0", wb2id_fwd); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", halt); end
    checks++; if (halt_code !== 64'h0) begin errors++; $display("FAIL reset_code: got %h want 0", halt_code); end
    checks++; if (cycle_cnt !== 64'h0 || instret_cnt !== 64'h0) begin errors++;
      $display("FAIL reset_cnt: got %h/%h want 0/0", cycle_cnt, instret_cnt); end
  endtask

  task automatic test_basic();
    drive(1'b0, 1'b0, 6'h00, '0);
    drive(1'b1, 1'b0, 6'h00, mk_bus(1'b1, 5'd5, 64'hDEAD, 64'h8000_0000, 32'h0050_0293));
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL basic_rf_we: got %b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL basic_waddr: got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 64'hDEAD) begin errors++; $display("FAIL basic_wdata: got %h want dead", rf_wdata); end
    checks++; if (wb2id_fwd !== {1'b1, 5'd5, 64'hDEAD}) begin errors++; $display("FAIL basic_fwd: got %h", wb2id_fwd); end
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL basic_commit: got %b want 1", commit_valid); end
    checks++; if (commit_pc !== 64'h8000_0000) begin errors++; $display("FAIL basic_pc: got %h want 80000000", commit_pc); end
    checks++; if (commit_inst !== 32'h0050_0293) begin errors++; $display("FAIL basic_inst: got %h want 00500293", commit_inst); end
    drive(1'b1, 1'b0, 6'h00, '0);
    checks++; if (instret_cnt !== (PERF ? 64'd1 : 64'd0)) begin errors++; $display("FAIL basic_instret: got %0d want %0d", instret_cnt, PERF ? 1 : 0); end
    checks++; if (cycle_cnt !== (PERF ? 64'd2 : 64'd0)) begin errors++; $display("FAIL basic_cycle: got %0d want %0d", cycle_cnt, PERF ? 2 : 0); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble: got %b want 0", commit_valid); end
  endtask

  task automatic test_stall_hold();
    drive(1'b0, 1'b0, 6'h00, '0);
    drive(1'b1, 1'b0, 6'h00, mk_bus(1'b1, 5'd7, 64'h77, 64'h8000_0004, 32'h0070_0393));
    checks++; if (commit_valid !== 1'b1 || rf_we !== 1'b1) begin errors++;
      $display("FAIL hold_first: got commit=%b we=%b want 1/1", commit_valid, rf_we); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 6'b110000, mk_bus(1'b1, 5'd9, 64'h99, 64'h0, 32'h1111_1111));
      checks++; if (commit_valid !== 1'b0 || rf_we !== 1'b0) begin errors++;
        $display("FAIL hold_again%0d: got commit=%b we=%b want 0/0", i, commit_valid, rf_we); end
      checks++; if (commit_inst !== 32'h0070_0393) begin errors++; $display("FAIL hold_inst%0d: got %h want 00700393", i, commit_inst); end
    end
    checks++; if (instret_cnt !== (PERF ? 64'd1 : 64'd0)) begin errors++; $display("FAIL hold_instret: got %0d", instret_cnt); end
    drive(1'b1, 1'b0, 6'b010000, mk_bus(1'b1, 5'd9, 64'h99, 64'h0, 32'h1111_1111));
    checks++; if (commit_inst !== 32'h0) begin errors++; $display("FAIL stall_bubble: got %h want 0", commit_inst); end
  endtask

  task automatic test_x0_flush();
    drive(1'b0, 1'b0, 6'h00, '0);
    drive(1'b1, 1'b0, 6'h00, mk_bus(1'b1, 5'd0, 64'h55, 64'h8000_0010, 32'h0000_0013));
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_rf_we: got %b want 0", rf_we); end
    checks++; if (wb2id_fwd[69] !== 1'b0) begin errors++; $display("FAIL x0_fwd_we: got %b want 0", wb2id_fwd[69]); end
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL x0_commit: got %b want 1", commit_valid); end
    drive(1'b1, 1'b1, 6'h00, mk_bus(1'b1, 5'd3, 64'h33, 64'h8000_0014, 32'h0030_0193));
    checks++; if (commit_valid !== 1'b0 || commit_inst !== 32'h0) begin errors++;
      $display("FAIL flush_bubble: got commit=%b inst=%h want 0/0", commit_valid, commit_inst); end
    drive(1'b1, 1'b0, 6'h00, mk_bus(1'b1, 5'd3, 64'h33, 64'h8000_0014, 32'h0030_0193));
    drive(1'b1, 1'b1, 6'b110000, mk_bus(1'b1, 5'd4, 64'h44, 64'h8000_0018, 32'h0040_0213));
    checks++; if (commit_inst !== 32'h0) begin errors++; $display("FAIL flush_over_stall: got %h want 0", commit_inst); end
  endtask

  task automatic test_halt();
    drive(1'b0, 1'b0, 6'h00, '0);
    drive(1'b1, 1'b0, 6'h00, mk_bus(1'b1, 5'd10, 64'd42, 64'h8000_0020, 32'h02A0_0513));
    drive(1'b1, 1'b0, 6'h00, mk_bus(1'b0, 5'd0, 64'h0, 64'h8000_0024, EBREAK));
    checks++; if (commit_valid !== 1'b1 || halt !== 1'b0) begin errors++;
      $display("FAIL ebreak_commit: got commit=%b halt=%b want 1/0", commit_valid, halt); end
    drive(1'b1, 1'b0, 6'h00, '0);
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halt); end
    checks++; if (halt_code !== 64'd42) begin errors++; $display("FAIL halt_code: got %0d want 42", halt_code); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 6'h00, mk_bus(1'b1, 5'd3, 64'h77, 64'h8000_0028, 32'h0770_0193));
      checks++; if (rf_we !== 1'b0 || commit_valid !== 1'b0) begin errors++;
        $display("FAIL halted_we%0d: got we=%b commit=%b want 0/0", i, rf_we, commit_valid); end
      checks++; if (cycle_cnt !== (PERF ? 64'd3 : 64'd0) || instret_cnt !== (PERF ? 64'd2 : 64'd0)) begin errors++;
        $display("FAIL halted_cnt%0d: got %0d/%0d", i, cycle_cnt, instret_cnt); end
      checks++; if (halt !== 1'b1 || halt_code !== 64'd42) begin errors++;
        $display("FAIL halted_sticky%0d: got %b/%0d want 1/42", i, halt, halt_code); end
    end
  endtask

  task automatic test_reset_halt();
    drive(1'b0, 1'b0, 6'h00, '0);
    checks++; if (halt !== 1'b0 || halt_code !== 64'h0) begin errors++;
      $display("FAIL rst_halt: got %b/%h want 0/0", halt, halt_code); end
    checks++; if (cycle_cnt !== 64'h0 || instret_cnt !== 64'h0) begin errors++;
      $display("FAIL rst_halt_cnt: got %h/%h want 0/0", cycle_cnt, instret_cnt); end
    drive(1'b1, 1'b0, 6'h00, mk_bus(1'b1, 5'd6, 64'hBEEF, 64'h8000_0030, 32'h0060_0313));
    checks++; if (commit_valid !== 1'b1 || rf_we !== 1'b1) begin errors++;
      $display("FAIL post_rst_commit: got %b/%b want 1/1", commit_valid, rf_we); end
    drive(1'b1, 1'b0, 6'h00, '0);
    checks++; if (instret_cnt !== (PERF ? 64'd1 : 64'd0)) begin errors++; $display("FAIL post_rst_instret: got %0d", instret_cnt); end
  endtask

  task automatic test_random();
    logic r, f;
    logic [5:0] s;
    logic [165:0] b;
    logic [4:0] wa;
    int k;
    drive(1'b0, 1'b0, 6'h00, '0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) != 0);
      f = ($urandom_range(0, 9) == 0);
      s = {$urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 4'($urandom())};
      k = $urandom_range(0, 19);
      wa = (k < 4) ? 5'd10 : (k < 6) ? 5'd0 : 5'($urandom());
      if (k < 5)       b = '0;
      else if (k == 5) b = mk_bus(1'b0, 5'd0, 64'h0, {$urandom(), $urandom()}, EBREAK);
      else             b = mk_bus(1'($urandom()), wa, {$urandom(), $urandom()}, {$urandom(), $urandom()}, $urandom() | 32'h1);
      drive(r, f, s, b);
      checks++; if (rf_we !== m_we()) begin errors++; $display("FAIL rnd_rf_we@%0d: got %b want %b", i, rf_we, m_we()); end
      checks++; if (rf_waddr !== m_bus[164:160] || rf_wdata !== m_bus[159:96]) begin errors++;
        $display("FAIL rnd_wport@%0d: got %0d/%h want %0d/%h", i, rf_waddr, rf_wdata, m_bus[164:160], m_bus[159:96]); end
      checks++; if (wb2id_fwd !== {m_we(), m_bus[164:96]}) begin errors++; $display("FAIL rnd_fwd@%0d: got %h", i, wb2id_fwd); end
      checks++; if (commit_valid !== m_fire()) begin errors++; $display("FAIL rnd_commit@%0d: got %b want %b", i, commit_valid, m_fire()); end
      checks++; if (commit_pc !== m_bus[95:32] || commit_inst !== m_bus[31:0]) begin errors++;
        $display("FAIL rnd_cinfo@%0d: got %h/%h want %h/%h", i, commit_pc, commit_inst, m_bus[95:32], m_bus[31:0]); end
      checks++; if (halt !== m_halted || halt_code !== m_a0) begin errors++;
        $display("FAIL rnd_halt@%0d: got %b/%h want %b/%h", i, halt, halt_code, m_halted, m_a0); end
      checks++; if (cycle_cnt !== e_cyc() || instret_cnt !== e_ret()) begin errors++;
        $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", i, cycle_cnt, instret_cnt, e_cyc(), e_ret()); end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = 6'h00; mem2wb_bus = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall_hold();
    test_x0_flush();
    test_halt();
    test_reset_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
